syst_ws_nxm: RTL and testbench
==============================

SYST_WS_NXM -- requirements
Module: syst_ws_nxm

Interface
REQ-001 SHALL have parameter DATA_W, default 8: unsigned width of each input sample and weight.
REQ-002 SHALL have parameter N_IN, default 3: input rows, and so the dot-product length.
REQ-003 SHALL have parameter N_OUT, default 2: output columns.
REQ-004 SHALL have parameter ACC_W, default 2*DATA_W+$clog2(N_IN)+1: per-output accumulator width.
REQ-005 SHALL have port clk_i, input, 1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port valid_i, input, 1: input vector valid.
REQ-008 SHALL have port ready_o, output, 1: input vector accepted when valid_i && ready_o.
REQ-009 SHALL have port x_i, input, N_IN*DATA_W: row r occupies bits [r*DATA_W +: DATA_W].
REQ-010 SHALL have port w_we_i, input, 1: shadow weight write strobe.
REQ-011 SHALL have port w_row_i, input, $clog2(N_IN): weight row index.
REQ-012 SHALL have port w_col_i, input, $clog2(N_OUT): weight column index.
REQ-013 SHALL have port w_data_i, input, DATA_W: weight value.
REQ-014 SHALL have port w_commit_i, input, 1: request to swap the shadow weights into the active weights.
REQ-015 SHALL have port w_busy_o, output, 1: a commit is in progress.
REQ-016 SHALL have port valid_o, output, 1: y_o holds a result.
REQ-017 SHALL have port y_o, output, N_OUT*ACC_W: column c occupies bits [c*ACC_W +: ACC_W].

Function
REQ-018 SHALL compute y[c] = sum over r of x[r]*Wa[r][c], unsigned, with no overflow, for each accepted vector.
REQ-019 SHALL be weight-stationary: PE(r,c) holds Wa[r][c]; x moves right one column per cycle; partial sums move down one row per cycle.
REQ-020 SHALL delay row r by r cycles before the array (input skew) and column c by N_OUT-1-c cycles after it (output deskew).
REQ-021 SHALL assert valid_o with the full y_o exactly L = N_IN+N_OUT-1 cycles after the accepting edge (4 cycles at defaults).
REQ-022 SHALL accept one vector per cycle back-to-back, with results emerging in order, one per cycle.
REQ-023 SHALL hold y_o at its last value while valid_o is 0.
REQ-024 SHALL write w_data_i to Ws[w_row_i][w_col_i] on a w_we_i cycle, in any state; out-of-range indices SHALL be ignored.
REQ-025 FSM states RUN, DRAIN, SWAP; ready_o = (state==RUN); w_busy_o = (state!=RUN).
REQ-026 In RUN, w_commit_i SHALL cause a transition to DRAIN; a vector accepted in that same cycle is computed with the old weights.
REQ-027 In DRAIN, the FSM SHALL wait until no vector is in flight (all stage valids 0), then go to SWAP; with nothing in flight it SHALL go to SWAP on the next cycle.
REQ-028 In SWAP, the FSM SHALL copy Wa <= Ws in one cycle and return to RUN.
REQ-029 A write in the SWAP cycle SHALL update Ws only and SHALL NOT reach Wa in that swap.
REQ-030 w_commit_i SHALL be ignored in DRAIN and SWAP.
REQ-031 Changing active weights SHALL never affect a vector already in flight.

Reset
REQ-032 On rst_i, the block SHALL clear all pipeline data, stage valids, Wa, Ws and y_o to 0, set valid_o=0, and set state=RUN, giving ready_o=1 and w_busy_o=0.
REQ-033 A reset mid-operation SHALL discard in-flight vectors; no valid_o SHALL appear for them afterwards.

Structure
REQ-034 A shared package syst_pkg SHALL hold the FSM state enum and a function for the default ACC_W.
REQ-035 A sub-module syst_pe SHALL implement one registered multiply-accumulate cell, with an x pass-through register and a partial-sum register.

Verification (defaults; Wa col0 = 1,2,3 and col1 = 4,5,6, loaded and committed)
REQ-036 x = (10,20,30), single valid -> after 4 cycles valid_o=1, y0=140, y1=320.
REQ-037 All x and all weights = 255 -> y0 = y1 = 195075, with no wrap.
REQ-038 Five back-to-back vectors -> five consecutive valid_o cycles with in-order correct results.
REQ-039 Commit one cycle after accepting a vector -> that result uses the old weights; ready_o=0 until the swap completes; the next vector uses the new weights.
REQ-040 rst_i asserted two cycles after accept -> valid_o stays 0, y_o=0, and ready_o=1 in the cycle after reset.

Source files
------------

// File: rtl/syst_pkg.sv
// Shared definitions for the weight-stationary systolic array: commit FSM states
// and the default accumulator width.
package syst_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SWAP
    } state_t;

    // Wide enough for N_IN full-scale unsigned products without wrap.
    function automatic int acc_width(input int data_w, input int n_in);
        return 2 * data_w + $clog2(n_in) + 1;
    endfunction

endpackage

// File: rtl/syst_pe.sv
// One weight-stationary MAC cell: registers x for the neighbour on the right and
// registers the partial sum from above plus x*w for the cell below.
module syst_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] w_i,
    input  logic [ACC_W-1:0]  psum_i,
    output logic [DATA_W-1:0] x_o,
    output logic [ACC_W-1:0]  psum_o
);

    logic [2*DATA_W-1:0] prod;

    assign prod = {{DATA_W{1'b0}}, x_i} * {{DATA_W{1'b0}}, w_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_o    <= '0;
            psum_o <= '0;
        end else begin
            x_o    <= x_i;
            psum_o <= psum_i + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/syst_ws_nxm.sv
// N_IN x N_OUT weight-stationary systolic array with skewed inputs, deskewed outputs
// and double-buffered weights swapped in only once the pipeline has drained.
module syst_ws_nxm
    import syst_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_IN   = 3,
    parameter int N_OUT  = 2,
    parameter int ACC_W  = acc_width(DATA_W, N_IN)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [N_IN*DATA_W-1:0]   x_i,
    input  logic                     w_we_i,
    input  logic [$clog2(N_IN)-1:0]  w_row_i,
    input  logic [$clog2(N_OUT)-1:0] w_col_i,
    input  logic [DATA_W-1:0]        w_data_i,
    input  logic                     w_commit_i,
    output logic                     w_busy_o,
    output logic                     valid_o,
    output logic [N_OUT*ACC_W-1:0]   y_o
);

    localparam int L     = N_IN + N_OUT - 1;
    localparam int ROW_W = $clog2(N_IN);
    localparam int COL_W = $clog2(N_OUT);
    localparam logic [ROW_W:0] ROW_LIM = (ROW_W + 1)'(N_IN);
    localparam logic [COL_W:0] COL_LIM = (COL_W + 1)'(N_OUT);

    state_t            state;
    logic [DATA_W-1:0] wa      [N_IN][N_OUT];
    logic [DATA_W-1:0] ws      [N_IN][N_OUT];
    logic [DATA_W-1:0] x_skew  [N_IN];
    logic [DATA_W-1:0] x_pe    [N_IN][N_OUT];
    logic [ACC_W-1:0]  psum_pe [N_IN][N_OUT];
    logic [ACC_W-1:0]  col_out [N_OUT];
    logic [L-1:0]      stage_v;
    logic              accept;
    logic              in_flight;
    logic              w_hit;
    logic              unused_x_tail;

    assign accept    = valid_i && ready_o;
    assign in_flight = |stage_v;
    assign w_hit     = w_we_i && ({1'b0, w_row_i} < ROW_LIM) && ({1'b0, w_col_i} < COL_LIM);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < N_IN; r++)
                for (int c = 0; c < N_OUT; c++)
                    ws[r][c] <= '0;
        end else if (w_hit) begin
            ws[w_row_i][w_col_i] <= w_data_i;
        end
    end

    // Active weights only change in SWAP, which is reached after every stage valid has cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= RUN;
            ready_o  <= 1'b1;
            w_busy_o <= 1'b0;
            for (int r = 0; r < N_IN; r++)
                for (int c = 0; c < N_OUT; c++)
                    wa[r][c] <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (w_commit_i) begin
                        state    <= DRAIN;
                        ready_o  <= 1'b0;
                        w_busy_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!in_flight)
                        state <= SWAP;
                end
                SWAP: begin
                    wa       <= ws;
                    state    <= RUN;
                    ready_o  <= 1'b1;
                    w_busy_o <= 1'b0;
                end
                default: begin
                    state    <= RUN;
                    ready_o  <= 1'b1;
                    w_busy_o <= 1'b0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < N_IN; r++) begin : g_row
        if (r == 0) begin : g_noskew
            assign x_skew[r] = x_i[r*DATA_W +: DATA_W];
        end else begin : g_skew
            logic [DATA_W-1:0] dly [r];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int k = 0; k < r; k++)
                        dly[k] <= '0;
                end else begin
                    dly[0] <= x_i[r*DATA_W +: DATA_W];
                    for (int k = 1; k < r; k++)
                        dly[k] <= dly[k-1];
                end
            end
            assign x_skew[r] = dly[r-1];
        end

        for (genvar c = 0; c < N_OUT; c++) begin : g_col
            logic [DATA_W-1:0] x_in;
            logic [ACC_W-1:0]  psum_in;

            if (c == 0) begin : g_xleft
                assign x_in = x_skew[r];
            end else begin : g_xmid
                assign x_in = x_pe[r][c-1];
            end

            if (r == 0) begin : g_ptop
                assign psum_in = '0;
            end else begin : g_pmid
                assign psum_in = psum_pe[r-1][c];
            end

            syst_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .x_i    (x_in),
                .w_i    (wa[r][c]),
                .psum_i (psum_in),
                .x_o    (x_pe[r][c]),
                .psum_o (psum_pe[r][c])
            );
        end
    end

    // Left columns finish early; delay them so every column lines up with the last one.
    for (genvar c = 0; c < N_OUT; c++) begin : g_deskew
        localparam int D = N_OUT - 1 - c;
        if (D == 0) begin : g_direct
            assign col_out[c] = psum_pe[N_IN-1][c];
        end else begin : g_delay
            logic [ACC_W-1:0] dly [D];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int k = 0; k < D; k++)
                        dly[k] <= '0;
                end else begin
                    dly[0] <= psum_pe[N_IN-1][c];
                    for (int k = 1; k < D; k++)
                        dly[k] <= dly[k-1];
                end
            end
            assign col_out[c] = dly[D-1];
        end
    end

    always_comb begin
        unused_x_tail = 1'b0;
        for (int r = 0; r < N_IN; r++)
            unused_x_tail = unused_x_tail ^ (^x_pe[r][N_OUT-1]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_v <= '0;
            valid_o <= 1'b0;
            y_o     <= '0;
        end else begin
            stage_v <= (stage_v << 1) | L'(accept);
            valid_o <= stage_v[L-1];
            if (stage_v[L-1]) begin
                for (int c = 0; c < N_OUT; c++)
                    y_o[c*ACC_W +: ACC_W] <= col_out[c];
            end
        end
    end

endmodule

// File: tb/tb_syst_ws_nxm.sv
// Self-checking bench for syst_ws_nxm: table-driven vectors, a scoreboard of expected
// results with latency, and hand-written commit / reset sequences.
module tb_syst_ws_nxm;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [23:0] x_i = '0;
    logic        w_we_i = 1'b0;
    logic [1:0]  w_row_i = '0;
    logic [0:0]  w_col_i = '0;
    logic [7:0]  w_data_i = '0;
    logic        w_commit_i = 1'b0;
    logic        w_busy_o;
    logic        valid_o;
    logic [37:0] y_o;

    typedef struct {
        logic [23:0] x;
        int          y0;
        int          y1;
    } vec_t;

    typedef struct {
        int y0;
        int y1;
        int acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[7];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    syst_ws_nxm dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .x_i        (x_i),
        .w_we_i     (w_we_i),
        .w_row_i    (w_row_i),
        .w_col_i    (w_col_i),
        .w_data_i   (w_data_i),
        .w_commit_i (w_commit_i),
        .w_busy_o   (w_busy_o),
        .valid_o    (valid_o),
        .y_o        (y_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] x, input int ey0, input int ey1);
        @(negedge clk);
        checkOutput("ready_o before accept", {63'd0, ready_o}, 64'd1);
        valid_i    = 1'b1;
        x_i        = x;
        w_we_i     = 1'b0;
        w_commit_i = 1'b0;
        sb.push_back('{ey0, ey1, cyc + 1});
    endtask

    task automatic idleCycle();
        @(negedge clk);
        valid_i    = 1'b0;
        w_we_i     = 1'b0;
        w_commit_i = 1'b0;
    endtask

    task automatic writeWeight(input logic [1:0] r, input logic [0:0] c, input logic [7:0] d);
        @(negedge clk);
        valid_i  = 1'b0;
        w_we_i   = 1'b1;
        w_row_i  = r;
        w_col_i  = c;
        w_data_i = d;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            @(negedge clk);
        checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
    endtask

    // Commit with nothing in flight: DRAIN lasts one cycle, then SWAP; optionally write Ws during SWAP.
    task automatic commitIdle(input bit swap_write, input logic [7:0] d);
        @(negedge clk);
        valid_i    = 1'b0;
        w_we_i     = 1'b0;
        w_commit_i = 1'b1;
        @(negedge clk);
        w_commit_i = 1'b0;
        checkOutput("w_busy_o in DRAIN", {63'd0, w_busy_o}, 64'd1);
        checkOutput("ready_o in DRAIN", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        checkOutput("w_busy_o in SWAP", {63'd0, w_busy_o}, 64'd1);
        if (swap_write) begin
            w_we_i   = 1'b1;
            w_row_i  = 2'd0;
            w_col_i  = 1'b0;
            w_data_i = d;
        end
        @(negedge clk);
        w_we_i = 1'b0;
        checkOutput("w_busy_o after SWAP", {63'd0, w_busy_o}, 64'd0);
        checkOutput("ready_o after SWAP", {63'd0, ready_o}, 64'd1);
    endtask

    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("valid_o with empty scoreboard", {63'd0, valid_o}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("y0", {45'd0, y_o[18:0]}, 64'(mon_e.y0));
                checkOutput("y1", {45'd0, y_o[37:19]}, 64'(mon_e.y1));
                checkOutput("latency", 64'(cyc - mon_e.acc), 64'(LAT));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Weights: column 0 = 1,2,3 and column 1 = 4,5,6
        tbl[0] = '{{8'd30, 8'd20, 8'd10}, 140, 320};
        tbl[1] = '{{8'd0, 8'd0, 8'd0}, 0, 0};
        tbl[2] = '{{8'd0, 8'd0, 8'd1}, 1, 4};
        tbl[3] = '{{8'd0, 8'd1, 8'd0}, 2, 5};
        tbl[4] = '{{8'd1, 8'd0, 8'd0}, 3, 6};
        tbl[5] = '{{8'd255, 8'd255, 8'd255}, 1530, 3825};
        tbl[6] = '{{8'd13, 8'd11, 8'd7}, 68, 161};

        @(negedge clk);
        checkOutput("reset ready_o", {63'd0, ready_o}, 64'd1);
        checkOutput("reset w_busy_o", {63'd0, w_busy_o}, 64'd0);
        checkOutput("reset valid_o", {63'd0, valid_o}, 64'd0);
        checkOutput("reset y_o", {26'd0, y_o}, 64'd0);
        @(negedge clk);
        rst_i = 1'b0;

        writeWeight(2'd0, 1'b0, 8'd1);
        writeWeight(2'd1, 1'b0, 8'd2);
        writeWeight(2'd2, 1'b0, 8'd3);
        writeWeight(2'd0, 1'b1, 8'd4);
        writeWeight(2'd1, 1'b1, 8'd5);
        writeWeight(2'd2, 1'b1, 8'd6);
        writeWeight(2'd3, 1'b0, 8'd99);
        idleCycle();
        commitIdle(1'b1, 8'd50);

        applyStimulus(tbl[0].x, tbl[0].y0, tbl[0].y1);
        idleCycle();
        waitDrain();
        for (int i = 1; i < 7; i++)
            applyStimulus(tbl[i].x, tbl[i].y0, tbl[i].y1);
        idleCycle();
        waitDrain();
        @(negedge clk);
        checkOutput("valid_o idle", {63'd0, valid_o}, 64'd0);
        checkOutput("y0 held", {45'd0, y_o[18:0]}, 64'd68);
        checkOutput("y1 held", {45'd0, y_o[37:19]}, 64'd161);

        // The SWAP-cycle write of 50 only reaches the active weights on this second commit
        commitIdle(1'b0, 8'd0);
        applyStimulus({8'd0, 8'd0, 8'd1}, 50, 4);
        applyStimulus({8'd30, 8'd20, 8'd10}, 630, 320);
        idleCycle();
        waitDrain();

        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++)
                writeWeight(2'(r), 1'(c), 8'd255);
        idleCycle();
        applyStimulus({8'd30, 8'd20, 8'd10}, 630, 320);
        @(negedge clk);
        valid_i    = 1'b0;
        w_commit_i = 1'b1;
        @(negedge clk);
        checkOutput("ready_o while draining", {63'd0, ready_o}, 64'd0);
        checkOutput("w_busy_o while draining", {63'd0, w_busy_o}, 64'd1);
        @(negedge clk);
        w_commit_i = 1'b0;
        for (int i = 0; i < 20 && ready_o !== 1'b1; i++)
            @(negedge clk);
        checkOutput("ready_o after commit", {63'd0, ready_o}, 64'd1);
        applyStimulus({8'd255, 8'd255, 8'd255}, 195075, 195075);
        applyStimulus({8'd3, 8'd2, 8'd1}, 1530, 1530);
        idleCycle();
        waitDrain();

        applyStimulus({8'd30, 8'd20, 8'd10}, 630, 320);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        sb.delete();
        @(negedge clk);
        rst_i = 1'b0;
        checkOutput("ready_o after mid reset", {63'd0, ready_o}, 64'd1);
        checkOutput("w_busy_o after mid reset", {63'd0, w_busy_o}, 64'd0);
        checkOutput("valid_o after mid reset", {63'd0, valid_o}, 64'd0);
        checkOutput("y_o after mid reset", {26'd0, y_o}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("no valid_o for discarded vector", {63'd0, valid_o}, 64'd0);
        end
        applyStimulus({8'd30, 8'd20, 8'd10}, 0, 0);
        idleCycle();
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
